// File: rtl/jspl_n.sv
// jspl_n: clocked 1-to-N SFQ splitter model with dead-time rejection,
// programmable input-to-output latency and fixed-width output pulses.
// Optional statistics counters are built when JSPL_N_STATS_EN is defined;
// otherwise acc_cnt and rej_cnt are tied to zero.
module jspl_n #(
  parameter int N_OUT    = 4,
  parameter int DELAY    = 4,
  parameter int WIDTH    = 2,
  parameter int INTERVAL = 6,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [N_OUT-1:0] en_mask,
  output logic [N_OUT-1:0] dout,
  output logic             reject,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] rej_cnt
);

  if (N_OUT < 2 || N_OUT > 32) begin : g_bad_n_out
    $error("jspl_n: N_OUT must be in 2..32");
  end
  if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
    $error("jspl_n: DELAY must be in 1..16");
  end
  if (INTERVAL < 1 || INTERVAL > 255) begin : g_bad_interval
    $error("jspl_n: INTERVAL must be in 1..255");
  end
  if (WIDTH < 1 || WIDTH > INTERVAL) begin : g_bad_width
    $error("jspl_n: WIDTH must be in 1..INTERVAL");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("jspl_n: CNT_W must be at least 1");
  end

  logic             din_q;
  logic [7:0]       gap;
  logic             rise;
  logic             accept;
  logic             rejected;
  logic [DELAY-1:0] vld;
  logic [N_OUT-1:0] msk [DELAY];
  logic [7:0]       wcnt;

  assign rise     = din & ~din_q;
  assign accept   = rise & (gap == 8'd0);
  assign rejected = rise & (gap != 8'd0);

  // Edge history, dead-time counter and the one-cycle reject flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q  <= 1'b0;
      gap    <= 8'd0;
      reject <= 1'b0;
    end else begin
      din_q  <= din;
      reject <= rejected;
      if (accept) begin
        gap <= 8'(INTERVAL);
      end else if (gap != 8'd0) begin
        gap <= gap - 8'd1;
      end
    end
  end

  // Delay line carrying each accepted event and the mask captured at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DELAY; i++) begin
        msk[i] <= '0;
      end
    end else begin
      vld[0] <= accept;
      msk[0] <= en_mask;
      for (int i = 1; i < DELAY; i++) begin
        vld[i] <= vld[i-1];
        msk[i] <= msk[i-1];
      end
    end
  end

  // Output pulse generator: launch on a valid last stage, clear after WIDTH cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      wcnt <= 8'd0;
    end else if (vld[DELAY-1]) begin
      dout <= msk[DELAY-1];
      wcnt <= 8'(WIDTH);
    end else if (wcnt != 8'd0) begin
      wcnt <= wcnt - 8'd1;
      if (wcnt == 8'd1) begin
        dout <= '0;
      end
    end
  end

`ifdef JSPL_N_STATS_EN
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] rej_q;

  // Saturating counters of accepted and rejected edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      rej_q <= '0;
    end else begin
      if (accept && acc_q != '1) begin
        acc_q <= acc_q + CNT_W'(1);
      end
      if (rejected && rej_q != '1) begin
        rej_q <= rej_q + CNT_W'(1);
      end
    end
  end

  assign acc_cnt = acc_q;
  assign rej_cnt = rej_q;
`else
  assign acc_cnt = '0;
  assign rej_cnt = '0;
`endif

endmodule
